// File: rtl/axil_mst_pkg.sv
// Shared types and constants for the AXI4-Lite command master.
package axil_mst_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RSP,
    RD_REQ,
    RD_RSP,
    RSP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int C_TIMEOUT_CYC_DEF = 1024;

endpackage

// File: rtl/axi4_lite_cmd_master.sv
// Single-outstanding command port to AXI4-Lite master; one transaction in flight, response on its own valid/ready.
// Optional watchdog recovery with AXIL_MST_TIMEOUT_EN (adds o_timeout).
module axi4_lite_cmd_master
  import axil_mst_pkg::*;
#(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_TIMEOUT_CYC      = C_TIMEOUT_CYC_DEF
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESETN,
  input  logic                            i_cmd_valid,
  output logic                            o_cmd_ready,
  input  logic                            i_cmd_wr,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   i_cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   i_cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] i_cmd_wstrb,
  output logic                            o_rsp_valid,
  input  logic                            i_rsp_ready,
  output logic                            o_rsp_wr,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   o_rsp_rdata,
  output logic [1:0]                      o_rsp_resp,
  output logic                            o_busy,
`ifdef AXIL_MST_TIMEOUT_EN
  output logic                            o_timeout,
`endif
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  if (C_M_AXI_DATA_WIDTH != 32) begin : g_bad_dw
    $error("axi4_lite_cmd_master supports only 32-bit data");
  end
  if (C_TIMEOUT_CYC < 2 || C_TIMEOUT_CYC > 65536) begin : g_bad_tmo
    $error("C_TIMEOUT_CYC must fit the 16-bit watchdog");
  end

  state_t                            r_state;
  logic [C_M_AXI_ADDR_WIDTH-1:0]     r_addr;
  logic [C_M_AXI_DATA_WIDTH-1:0]     r_wdata;
  logic [C_M_AXI_DATA_WIDTH/8-1:0]   r_wstrb;
  logic                              r_wr;
  logic                              r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
  logic                              r_rsp_valid, r_rsp_wr;
  logic [C_M_AXI_DATA_WIDTH-1:0]     r_rsp_rdata;
  logic [1:0]                        r_rsp_resp;

  // A channel counts as done once its VALID has dropped or is handshaking now.
  logic w_aw_done, w_w_done;
  assign w_aw_done = !r_awvalid || M_AXI_AWREADY;
  assign w_w_done  = !r_wvalid  || M_AXI_WREADY;

`ifdef AXIL_MST_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(C_TIMEOUT_CYC - 1);
  logic [15:0] r_tmo_cnt;
  logic        r_timeout;
  logic        w_tmo_state, w_state_chg;

  always_comb begin
    w_tmo_state = (r_state == WR_REQ) || (r_state == WR_RSP) ||
                  (r_state == RD_REQ) || (r_state == RD_RSP);
    w_state_chg = 1'b0;
    case (r_state)
      WR_REQ:  w_state_chg = w_aw_done && w_w_done;
      WR_RSP:  w_state_chg = M_AXI_BVALID;
      RD_REQ:  w_state_chg = M_AXI_ARREADY;
      RD_RSP:  w_state_chg = M_AXI_RVALID;
      default: w_state_chg = 1'b0;
    endcase
  end

  assign o_timeout = r_timeout;
`endif

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_wr        <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_wr    <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= RESP_OKAY;
`ifdef AXIL_MST_TIMEOUT_EN
      r_tmo_cnt   <= '0;
      r_timeout   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (i_cmd_valid) begin
            r_addr  <= i_cmd_addr;
            r_wdata <= i_cmd_wdata;
            r_wstrb <= i_cmd_wstrb;
            r_wr    <= i_cmd_wr;
            if (i_cmd_wr) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= WR_REQ;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          if (M_AXI_AWREADY) r_awvalid <= 1'b0;
          if (M_AXI_WREADY)  r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= WR_RSP;
          end
        end
        WR_RSP: begin
          if (M_AXI_BVALID) begin
            r_bready    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_wr    <= 1'b1;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= M_AXI_BRESP;
            r_state     <= RSP;
          end
        end
        RD_REQ: begin
          if (M_AXI_ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= RD_RSP;
          end
        end
        RD_RSP: begin
          if (M_AXI_RVALID) begin
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_wr    <= 1'b0;
            r_rsp_rdata <= M_AXI_RDATA;
            r_rsp_resp  <= M_AXI_RRESP;
            r_state     <= RSP;
          end
        end
        RSP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
`ifdef AXIL_MST_TIMEOUT_EN
      r_timeout <= 1'b0;
      if (!w_tmo_state || w_state_chg) r_tmo_cnt <= '0;
      else                             r_tmo_cnt <= r_tmo_cnt + 16'd1;
      // Abandon the hung transaction; later assignments override the case above.
      if (w_tmo_state && !w_state_chg && r_tmo_cnt == TMO_LAST) begin
        r_awvalid   <= 1'b0;
        r_wvalid    <= 1'b0;
        r_bready    <= 1'b0;
        r_arvalid   <= 1'b0;
        r_rready    <= 1'b0;
        r_rsp_valid <= 1'b1;
        r_rsp_wr    <= r_wr;
        r_rsp_rdata <= '0;
        r_rsp_resp  <= RESP_SLVERR;
        r_timeout   <= 1'b1;
        r_tmo_cnt   <= '0;
        r_state     <= RSP;
      end
`endif
    end
  end

  assign o_cmd_ready   = (r_state == IDLE) && M_AXI_ARESETN;
  assign o_busy        = (r_state != IDLE);
  assign o_rsp_valid   = r_rsp_valid;
  assign o_rsp_wr      = r_rsp_wr;
  assign o_rsp_rdata   = r_rsp_rdata;
  assign o_rsp_resp    = r_rsp_resp;
  assign M_AXI_AWADDR  = r_addr;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = r_wstrb;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_BREADY  = r_bready;
  assign M_AXI_ARADDR  = r_addr;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = r_arvalid;
  assign M_AXI_RREADY  = r_rready;

endmodule

// File: tb/tb_axi4_lite_cmd_master.sv
// Bench for axi4_lite_cmd_master: transaction-level model plus a small AXI4-Lite slave with configurable wait states.
module tb_axi4_lite_cmd_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cmd_valid = 1'b0, cmd_ready, cmd_wr = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_wr, busy;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [1:0]  bresp = 2'b00, rresp = 2'b00;
  logic [31:0] rdata = '0;
`ifdef AXIL_MST_TIMEOUT_EN
  logic        timeout;
`endif

  axi4_lite_cmd_master #(.C_TIMEOUT_CYC(16)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_wr(cmd_wr),
    .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata), .i_cmd_wstrb(cmd_wstrb),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_wr(rsp_wr),
    .o_rsp_rdata(rsp_rdata), .o_rsp_resp(rsp_resp), .o_busy(busy),
`ifdef AXIL_MST_TIMEOUT_EN
    .o_timeout(timeout),
`endif
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  int checks = 0, failures = 0;

  // Slave configuration and storage
  logic [31:0] mem [0:63];
  int          aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic        b_pend = 1'b0, r_pend = 1'b0;
  logic [31:0] sl_awaddr = '0, sl_wdata = '0, sl_araddr = '0;
  logic [3:0]  sl_wstrb = '0;
  int          b_hs_cnt = 0;

  // Transaction-level model of the command in flight
  logic        chk_en = 1'b1;
  logic        inflight = 1'b0, cur_wr = 1'b0;
  logic [31:0] cur_addr = '0, cur_wdata = '0;
  logic [3:0]  cur_wstrb = '0;
  logic        aw_seen = 1'b0, w_seen = 1'b0, b_seen = 1'b0, ar_seen = 1'b0, r_seen = 1'b0;
  logic        exp_wr = 1'b0;
  logic [31:0] exp_rdata = '0;
  logic [1:0]  exp_resp = 2'b00;
  logic        acc_pulse = 1'b0, rsp_pulse = 1'b0;
  logic        last_wr = 1'b0;
  logic [31:0] last_rdata = '0;
  logic [1:0]  last_resp = 2'b00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, 32'(act), 32'(exp));
  endtask

  task automatic model_reset();
    inflight = 1'b0; aw_seen = 1'b0; w_seen = 1'b0; b_seen = 1'b0;
    ar_seen = 1'b0; r_seen = 1'b0; b_pend = 1'b0; r_pend = 1'b0;
    acc_pulse = 1'b0; rsp_pulse = 1'b0;
  endtask

  task automatic monitor();
    logic due;
    due = inflight && (b_seen || r_seen);
    acc_pulse = 1'b0;
    rsp_pulse = 1'b0;
    if (chk_en) begin
      chk1("busy", busy, inflight);
      chk1("cmd_ready", cmd_ready, !inflight);
      chk1("awvalid", awvalid, inflight && cur_wr && !aw_seen);
      chk1("wvalid", wvalid, inflight && cur_wr && !w_seen);
      chk1("bready", bready, inflight && cur_wr && aw_seen && w_seen && !b_seen);
      chk1("arvalid", arvalid, inflight && !cur_wr && !ar_seen);
      chk1("rready", rready, inflight && !cur_wr && ar_seen && !r_seen);
      chk1("rsp_valid", rsp_valid, due);
      if (rsp_valid && due) begin
        chk1("rsp_wr", rsp_wr, exp_wr);
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        chk("rsp_resp", 32'(rsp_resp), 32'(exp_resp));
      end
      if (awvalid) begin
        chk("awaddr", awaddr, cur_addr);
        chk("awprot", 32'(awprot), 32'd0);
      end
      if (wvalid) begin
        chk("wdata", wdata, cur_wdata);
        chk("wstrb", 32'(wstrb), 32'(cur_wstrb));
      end
      if (arvalid) begin
        chk("araddr", araddr, cur_addr);
        chk("arprot", 32'(arprot), 32'd0);
      end
    end
    // Handshakes that complete at the coming rising edge
    if (awvalid && awready) begin aw_seen = 1'b1; sl_awaddr = awaddr; end
    if (wvalid && wready) begin w_seen = 1'b1; sl_wdata = wdata; sl_wstrb = wstrb; end
    if (aw_seen && w_seen && !b_pend && !b_seen) begin
      for (int k = 0; k < 4; k++)
        if (sl_wstrb[k]) mem[sl_awaddr[7:2]][8*k +: 8] = sl_wdata[8*k +: 8];
      b_pend = 1'b1;
    end
    if (bvalid && bready) begin b_seen = 1'b1; b_pend = 1'b0; b_hs_cnt++; end
    if (arvalid && arready) begin ar_seen = 1'b1; r_pend = 1'b1; sl_araddr = araddr; end
    if (rvalid && rready) begin r_seen = 1'b1; r_pend = 1'b0; end
    if (rsp_valid && rsp_ready) begin
      rsp_pulse = 1'b1;
      last_wr = rsp_wr; last_rdata = rsp_rdata; last_resp = rsp_resp;
      inflight = 1'b0;
    end
    if (cmd_valid && cmd_ready) begin
      acc_pulse = 1'b1;
      inflight = 1'b1; cur_wr = cmd_wr; cur_addr = cmd_addr;
      cur_wdata = cmd_wdata; cur_wstrb = cmd_wstrb;
      aw_seen = 1'b0; w_seen = 1'b0; b_seen = 1'b0; ar_seen = 1'b0; r_seen = 1'b0;
      exp_wr = cmd_wr;
      exp_rdata = cmd_wr ? 32'd0 : mem[cmd_addr[7:2]];
      exp_resp = cmd_wr ? bresp_cfg : rresp_cfg;
    end
  endtask

  task automatic slave_drive();
    if (!rst_n) begin
      awready = 1'b0; wready = 1'b0; arready = 1'b0; bvalid = 1'b0; rvalid = 1'b0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
    end else begin
      awready = awvalid && (aw_cnt >= aw_dly);
      aw_cnt  = awvalid ? aw_cnt + 1 : 0;
      wready  = wvalid && (w_cnt >= w_dly);
      w_cnt   = wvalid ? w_cnt + 1 : 0;
      arready = arvalid && (ar_cnt >= ar_dly);
      ar_cnt  = arvalid ? ar_cnt + 1 : 0;
      bvalid  = b_pend && (b_cnt >= b_dly);
      b_cnt   = b_pend ? b_cnt + 1 : 0;
      bresp   = bresp_cfg;
      rvalid  = r_pend && (r_cnt >= r_dly);
      r_cnt   = r_pend ? r_cnt + 1 : 0;
      rdata   = mem[sl_araddr[7:2]];
      rresp   = rresp_cfg;
    end
  endtask

  // One clock: observe at the falling edge, drive just after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (!rst_n) model_reset();
    else        monitor();
    @(posedge clk);
    #1;
    slave_drive();
  endtask

  task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] st);
    cmd_wr = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = st; cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (acc_pulse) break;
    end
    chk1("cmd_accepted", acc_pulse, 1'b1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    rsp_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      n++;
      if (rsp_pulse) break;
    end
    chk1("rsp_received", rsp_pulse, 1'b1);
    rsp_ready = 1'b0;
  endtask

  initial begin
    int n, b0;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    mem[2]  = 32'hFFFF_FFFF;
    mem[4]  = 32'h0000_7FFF;
    mem[11] = 32'hDEAD_BEEF;

    // Outputs during reset
    tick(); tick();
    chk1("rst_cmd_ready", cmd_ready, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_awvalid", awvalid, 1'b0);
    chk1("rst_wvalid", wvalid, 1'b0);
    chk1("rst_arvalid", arvalid, 1'b0);
    chk1("rst_bready", bready, 1'b0);
    chk1("rst_rready", rready, 1'b0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_prot", 32'({awprot, arprot}), 32'd0);
    rst_n = 1'b1;
    tick();

    // Zero-wait write
    b0 = b_hs_cnt;
    send(1'b1, 32'h0, 32'h0000_1388, 4'hF);
    wait_rsp(n);
    chk("wr_rsp_latency", 32'(n), 32'd3);
    chk1("wr_rsp_wr", last_wr, 1'b1);
    chk("wr_rsp_resp", 32'(last_resp), 32'd0);
    chk("wr_rsp_rdata", last_rdata, 32'd0);
    chk("slave_reg0", mem[0], 32'h0000_1388);
    chk("wr_b_count", 32'(b_hs_cnt - b0), 32'd1);

    // Read with 3 wait cycles on R
    r_dly = 3;
    send(1'b0, 32'h10, 32'h0, 4'h0);
    wait_rsp(n);
    chk("rd_rdata", last_rdata, 32'h0000_7FFF);
    chk("rd_resp", 32'(last_resp), 32'd0);
    chk1("rd_wr", last_wr, 1'b0);
    r_dly = 0;

    // W accepted 4 cycles before AW, partial strobes
    aw_dly = 4; b0 = b_hs_cnt;
    send(1'b1, 32'h8, 32'hA5A5_0001, 4'h3);
    wait_rsp(n);
    chk("split_b_count", 32'(b_hs_cnt - b0), 32'd1);
    chk("strobe_merge", mem[2], 32'hFFFF_0001);
    aw_dly = 0;

    // Response backpressure with the next command waiting
    send(1'b1, 32'hC, 32'h0000_0055, 4'hF);
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) break;
      tick();
    end
    chk1("bp_rsp_valid", rsp_valid, 1'b1);
    cmd_wr = 1'b0; cmd_addr = 32'h10; cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk1("bp_cmd_ready", cmd_ready, 1'b0);
      chk1("bp_hold_valid", rsp_valid, 1'b1);
      chk1("bp_hold_wr", rsp_wr, 1'b1);
      chk("bp_hold_rdata", rsp_rdata, 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    chk1("bp_rsp_taken", rsp_pulse, 1'b1);
    rsp_ready = 1'b0;
    tick();
    chk1("bp_accept_next_cycle", acc_pulse, 1'b1);
    cmd_valid = 1'b0;
    wait_rsp(n);
    chk("bp_next_rdata", last_rdata, 32'h0000_7FFF);

    // Slave error passthrough, then normal traffic
    rresp_cfg = 2'b10;
    send(1'b0, 32'h2C, 32'h0, 4'h0);
    wait_rsp(n);
    chk("err_resp", 32'(last_resp), 32'd2);
    chk("err_rdata", last_rdata, 32'hDEAD_BEEF);
    rresp_cfg = 2'b00;
    send(1'b1, 32'h2C, 32'h0000_1234, 4'hF);
    wait_rsp(n);
    send(1'b0, 32'h2C, 32'h0, 4'h0);
    wait_rsp(n);
    chk("after_err_rdata", last_rdata, 32'h0000_1234);
    chk("after_err_resp", 32'(last_resp), 32'd0);

    // Asynchronous reset in the middle of a write
    aw_dly = 100; w_dly = 100;
    send(1'b1, 32'h30, 32'h0000_0BAD, 4'hF);
    tick(); tick(); tick();
    chk1("mid_awvalid_pre", awvalid, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk1("mid_rst_awvalid", awvalid, 1'b0);
    chk1("mid_rst_wvalid", wvalid, 1'b0);
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_rsp_valid", rsp_valid, 1'b0);
    tick();
    rst_n = 1'b1;
    aw_dly = 0; w_dly = 0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    rsp_ready = 1'b0;
    chk("mid_rst_no_write", mem[12], 32'd0);
    send(1'b0, 32'h0, 32'h0, 4'h0);
    wait_rsp(n);
    chk("post_rst_rdata", last_rdata, 32'h0000_1388);

`ifdef AXIL_MST_TIMEOUT_EN
    // Hung AWREADY: watchdog fires after 16 cycles of WR_REQ
    chk_en = 1'b0;
    aw_dly = 1000;
    send(1'b1, 32'h40, 32'h0000_0001, 4'hF);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n++;
      if (timeout) break;
    end
    chk("tmo_cycle", 32'(n), 32'd16);
    chk1("tmo_rsp_valid", rsp_valid, 1'b1);
    chk("tmo_resp", 32'(rsp_resp), 32'd2);
    chk("tmo_rdata", rsp_rdata, 32'd0);
    chk1("tmo_awvalid", awvalid, 1'b0);
    tick();
    chk1("tmo_pulse_one", timeout, 1'b0);
    wait_rsp(n);
    aw_dly = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
